// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scanning channel multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2; returns 0 for n <= 1, so callers clamp to a minimum width of 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts enabled cycles 0..DWELL-1 and flags the last one.
// Latency: tc is combinational from en and the registered count.
// Backpressure: none; en stalls the count, clr returns it to zero.
module dwell_counter
    import mux_pkg::*;
#(
    parameter int DWELL = 4,
    localparam int CW = (clog2(DWELL) > 1) ? clog2(DWELL) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select or timed auto-scan, hold and wrap pulse.
// Latency: 1 cycle from data_in/sel/mode to out, cur_sel and wrap.
// Backpressure: none; data_in is sampled every edge, hold only freezes the scan position.
module mux_scan
    import mux_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SELW    = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           cur_sel,
    output logic                      wrap
);

    // One extra bit so the channel count itself is representable when CHANNELS = 2**SELW.
    localparam logic [SELW:0]   CH_NUM  = (SELW + 1)'(CHANNELS);
    localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);

    logic [SELW-1:0]  ch;
    logic [SELW-1:0]  ch_d;
    logic [WIDTH-1:0] out_d;
    logic             wrap_d;
    logic             scan_en;
    logic             tc;

    assign scan_en = (mode == MODE_SCAN) && !hold;

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (mode == MODE_MANUAL),
        .en    (scan_en),
        .tc    (tc)
    );

    always_comb begin
        ch_d   = ch;
        wrap_d = 1'b0;
        if (mode == MODE_MANUAL) begin
            if ({1'b0, sel} < CH_NUM) begin
                ch_d = sel;
            end
        end else if (tc) begin
            if (ch == CH_LAST) begin
                ch_d   = '0;
                wrap_d = 1'b1;
            end else begin
                ch_d = ch + 1'b1;
            end
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_d == SELW'(i)) begin
                out_d = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch   <= '0;
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            ch   <= ch_d;
            out  <= out_d;
            wrap <= wrap_d;
        end
    end

    assign cur_sel = ch;

endmodule
